// File: rtl/hs_unit_skid_buf.sv
// Two-entry valid/ready skid buffer. The main register drives m_data and the skid register
// catches the payload that arrives while the main entry is stalled.
module hs_unit_skid_buf #(
  parameter type DATA_TYPE = logic
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       s_valid,
  output logic       s_ready,
  input  DATA_TYPE   s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output DATA_TYPE   m_data,
  output logic [1:0] count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e   state_q, state_d;
  DATA_TYPE main_q, skid_q;
  logic     main_en, main_from_skid, skid_en;
  logic     s_fire, m_fire;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;
  assign m_data = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (s_fire) begin
          state_d = StBusy;
          main_en = 1'b1;
        end
      end
      StBusy: begin
        if (s_fire && !m_fire) begin
          state_d = StFull;
          skid_en = 1'b1;
        end else if (!s_fire && m_fire) begin
          state_d = StEmpty;
        end else if (s_fire && m_fire) begin
          main_en = 1'b1;
        end
      end
      StFull: begin
        if (m_fire) begin
          state_d        = StBusy;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over everything; the payload offered in the same cycle is dropped.
    if (flush) begin
      state_d = StEmpty;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    count   = 2'd0;
    unique case (state_q)
      StEmpty: begin
        s_ready = 1'b1;
        m_valid = 1'b0;
        count   = 2'd0;
      end
      StBusy: begin
        s_ready = 1'b1;
        m_valid = 1'b1;
        count   = 2'd1;
      end
      StFull: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        count   = 2'd2;
      end
      default: begin
        s_ready = 1'b1;
        m_valid = 1'b0;
        count   = 2'd0;
      end
    endcase
  end

  // Payload registers carry no reset; they load only when a transfer targets them.
  always_ff @(posedge clk) begin
    if (main_en) begin
      main_q <= main_from_skid ? skid_q : s_data;
    end
    if (skid_en) begin
      skid_q <= s_data;
    end
  end

endmodule
